// File: rtl/vga_pkg.sv
// -----------------------------------------------------------------------------
// vga_pkg
// Shared definitions for the VGA raster timing generator.
//   - default 640x480@60 timing constants (active / porches / sync widths)
//   - derived line and frame totals (16-bit unsigned)
//   - default sync polarities (0 = active-low)
//   - vga_pins_t: the registered pin bundle driven by vga_timing_gen
//   - sync_level(): maps "inside sync window" to the pin level for a polarity
// -----------------------------------------------------------------------------
package vga_pkg;

   localparam logic [15:0] DEF_H_ACTIVE = 16'd640;
   localparam logic [15:0] DEF_H_FP     = 16'd16;
   localparam logic [15:0] DEF_H_SYNC   = 16'd96;
   localparam logic [15:0] DEF_H_BP     = 16'd48;

   localparam logic [15:0] DEF_V_ACTIVE = 16'd480;
   localparam logic [15:0] DEF_V_FP     = 16'd10;
   localparam logic [15:0] DEF_V_SYNC   = 16'd2;
   localparam logic [15:0] DEF_V_BP     = 16'd33;

   localparam logic [15:0] DEF_H_TOTAL = DEF_H_ACTIVE + DEF_H_FP + DEF_H_SYNC + DEF_H_BP;
   localparam logic [15:0] DEF_V_TOTAL = DEF_V_ACTIVE + DEF_V_FP + DEF_V_SYNC + DEF_V_BP;

   localparam logic DEF_HS_POL = 1'b0;
   localparam logic DEF_VS_POL = 1'b0;

   typedef struct packed {
      logic       hs;
      logic       vs;
      logic       de;
      logic [7:0] r;
      logic [7:0] g;
      logic [7:0] b;
   } vga_pins_t;

   // Pin level for a sync decode: the active level inside the window,
   // the idle (inverted) level outside it.
   function automatic logic sync_level(input logic in_window, input logic pol);
      return in_window ? pol : ~pol;
   endfunction

endpackage

// File: rtl/vga_axis_counter.sv
// -----------------------------------------------------------------------------
// vga_axis_counter
// One raster axis: a 0..TOTAL-1 wrap counter with enable, plus the decodes
// that depend only on this axis.
//
// Parameters:
//   TOTAL       counts per period (counter wraps from TOTAL-1 to 0)
//   ACTIVE      first non-visible count
//   SYNC_START  first count inside the sync window
//   SYNC_END    first count after the sync window
//
// Ports:
//   clk      in   pixel clock
//   rst      in   synchronous active-high reset (value -> 0)
//   en       in   advance enable
//   value    out  16  counter register
//   wrap     out  1   high on the enabled cycle that takes value back to 0
//   active   out  1   value < ACTIVE
//   in_sync  out  1   SYNC_START <= value < SYNC_END
// -----------------------------------------------------------------------------
module vga_axis_counter #(
   parameter logic [15:0] TOTAL      = 16'd800,
   parameter logic [15:0] ACTIVE     = 16'd640,
   parameter logic [15:0] SYNC_START = 16'd656,
   parameter logic [15:0] SYNC_END   = 16'd752
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        en,
   output logic [15:0] value,
   output logic        wrap,
   output logic        active,
   output logic        in_sync
);

   localparam logic [15:0] LAST = TOTAL - 16'd1;

   assign wrap    = en && (value == LAST);
   assign active  = (value < ACTIVE);
   assign in_sync = (value >= SYNC_START) && (value < SYNC_END);

   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments so every
      // register samples pre-edge values, independent of block ordering.
      if (rst) begin
         value <= '0;
      end else if (wrap) begin
         value <= '0;
      end else if (en) begin
         value <= value + 16'd1;
      end
   end

endmodule

// File: rtl/vga_timing_gen.sv
// -----------------------------------------------------------------------------
// vga_timing_gen
// Raster timing generator. Publishes the raw pixel counters (x, y) to the
// pattern block, takes its combinational colour answer and emits registered,
// mutually aligned VGA pins one clock after the coordinates.
//
// Optional feature (compile-time macro VGA_TIMING_BLANK_EN):
//   defined   -> colour register loads 0 whenever the pixel is outside the
//                active area
//   undefined -> colour register loads r/g/b unconditionally
//
// Ports:
//   clk                  in   pixel clock (only clock)
//   rst                  in   synchronous active-high reset
//   x, y                 out  16  horizontal / vertical counter registers
//   sof                  out  1   start of frame, high while x==0 && y==0
//   r, g, b              in   8   colour for the current (x, y)
//   vga_hs, vga_vs       out  1   sync pins (polarity HS_POL / VS_POL)
//   vga_de               out  1   active-video enable
//   vga_r, vga_g, vga_b  out  8   registered colour
// -----------------------------------------------------------------------------
module vga_timing_gen
   import vga_pkg::*;
#(
   parameter logic [15:0] H_ACTIVE = DEF_H_ACTIVE,
   parameter logic [15:0] H_FP     = DEF_H_FP,
   parameter logic [15:0] H_SYNC   = DEF_H_SYNC,
   parameter logic [15:0] H_BP     = DEF_H_BP,
   parameter logic [15:0] V_ACTIVE = DEF_V_ACTIVE,
   parameter logic [15:0] V_FP     = DEF_V_FP,
   parameter logic [15:0] V_SYNC   = DEF_V_SYNC,
   parameter logic [15:0] V_BP     = DEF_V_BP,
   parameter logic        HS_POL   = DEF_HS_POL,
   parameter logic        VS_POL   = DEF_VS_POL
) (
   input  logic        clk,
   input  logic        rst,
   output logic [15:0] x,
   output logic [15:0] y,
   output logic        sof,
   input  logic [7:0]  r,
   input  logic [7:0]  g,
   input  logic [7:0]  b,
   output logic        vga_hs,
   output logic        vga_vs,
   output logic        vga_de,
   output logic [7:0]  vga_r,
   output logic [7:0]  vga_g,
   output logic [7:0]  vga_b
);

   localparam logic [15:0] H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam logic [15:0] V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

   localparam vga_pins_t PINS_RESET = '{
      hs: ~HS_POL, vs: ~VS_POL, de: 1'b0, r: 8'h00, g: 8'h00, b: 8'h00
   };

   logic      h_wrap, h_active, h_sync;
   logic      v_wrap_unused, v_active, v_sync;
   logic      de_c;
   vga_pins_t pins_next;
   vga_pins_t pins_q;

   vga_axis_counter #(
      .TOTAL      (H_TOTAL),
      .ACTIVE     (H_ACTIVE),
      .SYNC_START (H_ACTIVE + H_FP),
      .SYNC_END   (H_ACTIVE + H_FP + H_SYNC)
   ) u_h_counter (
      .clk     (clk),
      .rst     (rst),
      .en      (1'b1),
      .value   (x),
      .wrap    (h_wrap),
      .active  (h_active),
      .in_sync (h_sync)
   );

   // The vertical axis advances only on the horizontal wrap, so its own wrap
   // is automatically coincident with the end of the last line.
   vga_axis_counter #(
      .TOTAL      (V_TOTAL),
      .ACTIVE     (V_ACTIVE),
      .SYNC_START (V_ACTIVE + V_FP),
      .SYNC_END   (V_ACTIVE + V_FP + V_SYNC)
   ) u_v_counter (
      .clk     (clk),
      .rst     (rst),
      .en      (h_wrap),
      .value   (y),
      .wrap    (v_wrap_unused),
      .active  (v_active),
      .in_sync (v_sync)
   );

   assign de_c = h_active && v_active;
   assign sof  = (x == 16'd0) && (y == 16'd0);

   always_comb begin
      // NOTE: every field gets a value before any conditional override so
      // this block can never infer a latch.
      pins_next.hs = sync_level(h_sync, HS_POL);
      pins_next.vs = sync_level(v_sync, VS_POL);
      pins_next.de = de_c;
      pins_next.r  = r;
      pins_next.g  = g;
      pins_next.b  = b;
`ifdef VGA_TIMING_BLANK_EN
      if (!de_c) begin
         pins_next.r = 8'h00;
         pins_next.g = 8'h00;
         pins_next.b = 8'h00;
      end
`endif
   end

   // Single output stage shared by syncs, enable and colour keeps them
   // aligned with each other, one clock behind x/y.
   always_ff @(posedge clk) begin
      if (rst) begin
         pins_q <= PINS_RESET;
      end else begin
         pins_q <= pins_next;
      end
   end

   assign vga_hs = pins_q.hs;
   assign vga_vs = pins_q.vs;
   assign vga_de = pins_q.de;
   assign vga_r  = pins_q.r;
   assign vga_g  = pins_q.g;
   assign vga_b  = pins_q.b;

endmodule

// File: tb/tb_vga_timing_gen.sv
// -----------------------------------------------------------------------------
// tb_vga_timing_gen
// Self-checking bench for vga_timing_gen. Two instances share the clock:
//   - dut_f: default 640x480@60 timing (reset, hsync, line wrap, mid-line reset)
//   - dut_s: a tiny raster (19 x 11, active-high hsync) so whole frames,
//            vsync and the simultaneous wrap fit in a short run
// The reference model derives every expected value from the number of clocks
// since the last reset: x = n mod H_TOTAL, y = (n div H_TOTAL) mod V_TOTAL,
// pins = decode of the previous cycle's coordinates and colour inputs.
// Honours VGA_TIMING_BLANK_EN the same way the design does.
// -----------------------------------------------------------------------------
module tb_vga_timing_gen;

   typedef struct packed {
      int ha, hfp, hsw, hbp;
      int va, vfp, vsw, vbp;
      bit hpol, vpol;
   } timing_t;

   typedef struct packed {
      logic       hs;
      logic       vs;
      logic       de;
      logic [7:0] r;
      logic [7:0] g;
      logic [7:0] b;
   } pins_t;

   localparam timing_t FT = '{ha: 640, hfp: 16, hsw: 96, hbp: 48,
                              va: 480, vfp: 10, vsw: 2, vbp: 33,
                              hpol: 1'b0, vpol: 1'b0};
   localparam timing_t ST = '{ha: 10, hfp: 2, hsw: 3, hbp: 4,
                              va: 6, vfp: 1, vsw: 2, vbp: 2,
                              hpol: 1'b1, vpol: 1'b0};

   logic        clk = 1'b0;
   logic        rst_f, rst_s;
   logic [7:0]  r_f, g_f, b_f, r_s, g_s, b_s;
   logic [15:0] x_f, y_f, x_s, y_s;
   logic        sof_f, sof_s;
   logic        vga_hs_f, vga_vs_f, vga_de_f, vga_hs_s, vga_vs_s, vga_de_s;
   logic [7:0]  vga_r_f, vga_g_f, vga_b_f, vga_r_s, vga_g_s, vga_b_s;

   int tests_run = 0;
   int tests_failed = 0;
   int cyc = 0;
   int n_f = 0, n_s = 0;
   pins_t exp_f, exp_s;

   always #5 clk = ~clk;

   vga_timing_gen dut_f (
      .clk(clk), .rst(rst_f), .x(x_f), .y(y_f), .sof(sof_f),
      .r(r_f), .g(g_f), .b(b_f),
      .vga_hs(vga_hs_f), .vga_vs(vga_vs_f), .vga_de(vga_de_f),
      .vga_r(vga_r_f), .vga_g(vga_g_f), .vga_b(vga_b_f)
   );

   vga_timing_gen #(
      .H_ACTIVE(16'd10), .H_FP(16'd2), .H_SYNC(16'd3), .H_BP(16'd4),
      .V_ACTIVE(16'd6),  .V_FP(16'd1), .V_SYNC(16'd2), .V_BP(16'd2),
      .HS_POL(1'b1), .VS_POL(1'b0)
   ) dut_s (
      .clk(clk), .rst(rst_s), .x(x_s), .y(y_s), .sof(sof_s),
      .r(r_s), .g(g_s), .b(b_s),
      .vga_hs(vga_hs_s), .vga_vs(vga_vs_s), .vga_de(vga_de_s),
      .vga_r(vga_r_s), .vga_g(vga_g_s), .vga_b(vga_b_s)
   );

   function automatic int htot(timing_t t);
      return t.ha + t.hfp + t.hsw + t.hbp;
   endfunction

   function automatic int vtot(timing_t t);
      return t.va + t.vfp + t.vsw + t.vbp;
   endfunction

   function automatic pins_t reset_pins(timing_t t);
      pins_t p;
      p.hs = ~t.hpol;
      p.vs = ~t.vpol;
      p.de = 1'b0;
      p.r  = 8'h00;
      p.g  = 8'h00;
      p.b  = 8'h00;
      return p;
   endfunction

   // Pins one clock after the raster sat at position n with inputs (ri,gi,bi).
   function automatic pins_t expect_pins(timing_t t, int n,
                                         logic [7:0] ri, logic [7:0] gi, logic [7:0] bi);
      pins_t p;
      int cx, cy;
      bit hs_win, vs_win;
      cx = n % htot(t);
      cy = (n / htot(t)) % vtot(t);
      hs_win = (cx >= t.ha + t.hfp) && (cx < t.ha + t.hfp + t.hsw);
      vs_win = (cy >= t.va + t.vfp) && (cy < t.va + t.vfp + t.vsw);
      p.hs = hs_win ? t.hpol : ~t.hpol;
      p.vs = vs_win ? t.vpol : ~t.vpol;
      p.de = (cx < t.ha) && (cy < t.va);
      p.r  = ri;
      p.g  = gi;
      p.b  = bi;
`ifdef VGA_TIMING_BLANK_EN
      if (!p.de) begin
         p.r = 8'h00;
         p.g = 8'h00;
         p.b = 8'h00;
      end
`endif
      return p;
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      tests_run++;
      assert (obs === expv) else begin
         tests_failed++;
         $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, expv, cyc);
      end
   endtask

   task automatic check_dut(input string tag, input timing_t t, input int n, input pins_t e,
                            input logic [15:0] xo, input logic [15:0] yo, input logic so,
                            input pins_t got);
      int ex, ey;
      ex = n % htot(t);
      ey = (n / htot(t)) % vtot(t);
      check({tag, ".x"},   32'(xo), 32'(ex));
      check({tag, ".y"},   32'(yo), 32'(ey));
      check({tag, ".sof"}, 32'(so), 32'((ex == 0) && (ey == 0)));
      check({tag, ".hs"},  32'(got.hs), 32'(e.hs));
      check({tag, ".vs"},  32'(got.vs), 32'(e.vs));
      check({tag, ".de"},  32'(got.de), 32'(e.de));
      check({tag, ".r"},   32'(got.r),  32'(e.r));
      check({tag, ".g"},   32'(got.g),  32'(e.g));
      check({tag, ".b"},   32'(got.b),  32'(e.b));
   endtask

   task automatic drive_rgb();
      // Mix all-ones (blanking visibility) with random colours.
      if ($urandom_range(0, 3) == 0) begin
         r_f = 8'hff; g_f = 8'hff; b_f = 8'hff;
         r_s = 8'hff; g_s = 8'hff; b_s = 8'hff;
      end else begin
         r_f = 8'($urandom); g_f = 8'($urandom); b_f = 8'($urandom);
         r_s = 8'($urandom); g_s = 8'($urandom); b_s = 8'($urandom);
      end
   endtask

   // One clock: advance the model on the edge, check both DUTs 1 time unit
   // later, then present fresh colour inputs for the next edge.
   task automatic tick();
      @(posedge clk);
      if (rst_f) begin
         n_f = 0;
         exp_f = reset_pins(FT);
      end else begin
         exp_f = expect_pins(FT, n_f, r_f, g_f, b_f);
         n_f++;
      end
      if (rst_s) begin
         n_s = 0;
         exp_s = reset_pins(ST);
      end else begin
         exp_s = expect_pins(ST, n_s, r_s, g_s, b_s);
         n_s++;
      end
      #1;
      cyc++;
      check_dut("f", FT, n_f, exp_f, x_f, y_f, sof_f,
                '{vga_hs_f, vga_vs_f, vga_de_f, vga_r_f, vga_g_f, vga_b_f});
      check_dut("s", ST, n_s, exp_s, x_s, y_s, sof_s,
                '{vga_hs_s, vga_vs_s, vga_de_s, vga_r_s, vga_g_s, vga_b_s});
      drive_rgb();
   endtask

   initial begin
      int lx, sx, sy;
      logic lhs, lvs, lsof;
      int hs_fall_x, hs_rise_x, hs_low;
      int vs_fall_x, vs_fall_y, vs_low;
      bit vs_done, found;
      int last_sof, period;

      rst_f = 1'b1;
      rst_s = 1'b1;
      drive_rgb();

      // Reset held for 3 clocks: counters at origin, pins idle, sof high.
      repeat (3) tick();
      check("f.rst_hs", 32'(vga_hs_f), 32'd1);
      check("f.rst_vs", 32'(vga_vs_f), 32'd1);
      check("f.rst_sof", 32'(sof_f), 32'd1);
      rst_f = 1'b0;
      rst_s = 1'b0;
      check("f.rst_sof_after", 32'(sof_f), 32'd1);

      // First line of dut_f (hsync window) and several frames of dut_s.
      hs_fall_x = -1; hs_rise_x = -1; hs_low = 0;
      vs_fall_x = -1; vs_fall_y = -1; vs_low = 0; vs_done = 0;
      last_sof = -1; period = -1;
      for (int i = 0; i < 801; i++) begin
         lx = x_f; lhs = vga_hs_f;
         sx = x_s; sy = y_s; lvs = vga_vs_s; lsof = sof_s;
         tick();
         if (lhs && !vga_hs_f && hs_fall_x < 0) hs_fall_x = lx;
         if (!lhs && vga_hs_f && hs_rise_x < 0) hs_rise_x = lx;
         if (!vga_hs_f && hs_rise_x < 0) hs_low++;
         if (lvs && !vga_vs_s && vs_fall_x < 0) begin
            vs_fall_x = sx;
            vs_fall_y = sy;
         end
         if (vs_fall_x >= 0 && !vs_done) begin
            if (!vga_vs_s) vs_low++;
            else vs_done = 1;
         end
         if (!lsof && sof_s) begin
            if (last_sof >= 0 && period < 0) period = cyc - last_sof;
            last_sof = cyc;
         end
         if (sx == htot(ST) - 1 && sy == vtot(ST) - 1) begin
            check("s.frame_wrap_x", 32'(x_s), 32'd0);
            check("s.frame_wrap_y", 32'(y_s), 32'd0);
            check("s.frame_wrap_sof", 32'(sof_s), 32'd1);
         end
      end
      check("f.hs_fall_after_x", 32'(hs_fall_x), 32'd656);
      check("f.hs_rise_after_x", 32'(hs_rise_x), 32'd752);
      check("f.hs_low_clocks", 32'(hs_low), 32'd96);
      check("s.vs_fall_after_x", 32'(vs_fall_x), 32'd0);
      check("s.vs_fall_after_y", 32'(vs_fall_y), 32'(ST.va + ST.vfp));
      check("s.vs_low_clocks", 32'(vs_low), 32'(ST.vsw * htot(ST)));
      check("s.frame_period", 32'(period), 32'(htot(ST) * vtot(ST)));

      // dut_f line wrap at (799,10) -> (0,11).
      found = 0;
      for (int i = 0; i < 20000 && !found; i++) begin
         if (x_f == 16'd799 && y_f == 16'd10) found = 1;
         else tick();
      end
      check("f.reach_799_10", 32'(found), 32'd1);
      tick();
      check("f.line_wrap_x", 32'(x_f), 32'd0);
      check("f.line_wrap_y", 32'(y_f), 32'd11);

      // Mid-line reset on dut_f at x=300: origin and blanked on the next edge.
      found = 0;
      for (int i = 0; i < 2000 && !found; i++) begin
         if (x_f == 16'd300) found = 1;
         else tick();
      end
      check("f.reach_x300", 32'(found), 32'd1);
      rst_f = 1'b1;
      tick();
      rst_f = 1'b0;
      check("f.midrst_x", 32'(x_f), 32'd0);
      check("f.midrst_y", 32'(y_f), 32'd0);
      check("f.midrst_de", 32'(vga_de_f), 32'd0);
      repeat (900) tick();
      check("f.resume_y", 32'(y_f), 32'd1);

      // Random reset pulses on dut_s; the model tracks every restart.
      for (int i = 0; i < 2000; i++) begin
         rst_s = ($urandom_range(0, 63) == 0);
         tick();
      end
      rst_s = 1'b0;
      repeat (5) tick();

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule

// File: doc/vga_timing_gen.md
# vga_timing_gen

Raster timing generator that drives the pixel coordinate bus (`x`, `y`) consumed by pattern/sprite blocks. It takes their combinational `r`/`g`/`b` answer and emits registered, sync-aligned VGA pins: `vga_hs`, `vga_vs`, `vga_de`, `vga_r`/`vga_g`/`vga_b`. It sits between the pixel-clock domain root and the board video DAC/HDMI encoder, and is the source end of the x/y → rgb pixel interface.

## Interface
- `H_ACTIVE`, 640, visible pixels per line
- `H_FP`, 16, horizontal front porch (clocks)
- `H_SYNC`, 96, hsync pulse width (clocks)
- `H_BP`, 48, horizontal back porch (clocks)
- `V_ACTIVE`, 480, visible lines per frame
- `V_FP`, 10, vertical front porch (lines)
- `V_SYNC`, 2, vsync pulse width (lines)
- `V_BP`, 33, vertical back porch (lines)
- `HS_POL`, 0, hsync active level (0 = active-low)
- `VS_POL`, 0, vsync active level (0 = active-low)

Ports:
- `clk`  in  1  pixel clock; the only clock
- `rst`  in  1  reset, synchronous, active-high
- `x`  out  16  horizontal counter value, 0..H_TOTAL-1
- `y`  out  16  vertical counter value, 0..V_TOTAL-1
- `sof`  out  1  start of frame; high while x==0 && y==0
- `r`, `g`, `b`  in  8 each  pixel colour for current (`x`, `y`); combinational from the pattern block
- `vga_hs`, `vga_vs`  out  1 each  sync pins
- `vga_de`  out  1  active-video enable
- `vga_r`, `vga_g`, `vga_b`  out  8 each  registered colour

## Operation
- H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP (800); V_TOTAL likewise (525). All sums are 16-bit unsigned.
- `x` increments by 1 every clock. At H_TOTAL-1, `x` wraps to 0.
- `y` increments only when `x` wraps. At V_TOTAL-1, `y` wraps to 0, coincident with the `x` wrap.
- `x` and `y` are the counter registers themselves. They are not gated to the active area. Consumers must return 0 colour for x ≥ H_ACTIVE or y ≥ V_ACTIVE, or rely on blanking.
- Raw (pre-register) decodes:
  - de_c = (x < H_ACTIVE) && (y < V_ACTIVE)
  - hs_c = (x ≥ H_ACTIVE+H_FP) && (x < H_ACTIVE+H_FP+H_SYNC)
  - vs_c = (y ≥ V_ACTIVE+V_FP) && (y < V_ACTIVE+V_FP+V_SYNC)
- Output register loads every clock:
  - `vga_hs` ← hs_c ? HS_POL : ~HS_POL
  - `vga_vs` ← vs_c ? VS_POL : ~VS_POL
  - `vga_de` ← de_c
  - `vga_r`/`vga_g`/`vga_b` ← `r`/`g`/`b` (see Configuration)
- `sof` is combinational from the counters.

## Timing
- Reset values: `x`=0, `y`=0, `vga_hs`=~HS_POL, `vga_vs`=~VS_POL, `vga_de`=0, `vga_r`/`vga_g`/`vga_b`=0.
- `sof` reads 1 while in reset and on the first cycle after reset, because the counters are at (0,0).
- Latency: the pin outputs lag `x`/`y` by exactly 1 clock. Colour and syncs share this one stage, so they stay mutually aligned.
- Reset mid-frame: takes effect on the next clock edge. The counters return to (0,0) and the pins take their reset values on that same edge. No partial-line completion.
- Simultaneous wrap: at (H_TOTAL-1, V_TOTAL-1), the next clock gives (0,0) and `sof`=1.
- hsync asserts on every line, including vertical blanking lines.

## Configuration
- `VGA_TIMING_BLANK_EN` defined: colour register loads 0 whenever de_c=0, so `vga_r`/`vga_g`/`vga_b` are 0 outside active video regardless of input.
- Macro undefined: colour register loads `r`/`g`/`b` unconditionally.

## Structure
- Shared package `vga_pkg` holds:
  - default 640x480@60 timing constants
  - derived H_TOTAL/V_TOTAL
  - the polarity constants
- One sub-module, `vga_axis_counter`: parameterised wrap counter with enable, producing value, wrap pulse and sync-window decode.
  - Horizontal instance: enable tied high.
  - Vertical instance: enable driven by the horizontal wrap pulse.

## Test plan
- Reset: hold `rst`=1 for 3 clocks → `x`=0, `y`=0, `vga_hs`=1, `vga_vs`=1, `vga_de`=0, RGB=0, `sof`=1.
- Hsync: run from reset → `vga_hs` goes 0 on the clock after `x`=656, stays 0 for exactly 96 clocks, returns to 1 after `x`=752.
- Line/frame wrap:
  - `x`=799, `y`=10 → next clock gives `x`=0, `y`=11.
  - `x`=799, `y`=524 → next clock gives (0,0) and `sof`=1.
  - Frame period is 420000 clocks.
- Vsync: `vga_vs` is 0 for exactly 1600 clocks, starting 1 clock after (`x`=0, `y`=490).
- Blanking: drive `r`=`g`=`b`=8'hff constantly.
  - With `VGA_TIMING_BLANK_EN`: RGB=ff only when `vga_de`=1, else 0.
  - Without the macro: RGB=ff everywhere after the first clock.
- Mid-frame reset: pulse `rst` for 1 clock at (300,200) → next clock gives (0,0), `vga_de`=0; counting resumes normally.
